apb_master: RTL and testbench
=============================

# apb_master

Command-driven APB master that sits directly upstream of the `apb` dual-port memory slave and drives its `apb_if` pins. Buffers simple read/write requests from a local requester in a small FIFO, then executes each one as a compliant APB SETUP/ACCESS transfer. Returns read data and error status on a valid/ready response channel. Handles one transfer at a time, in request order.

## Interface
- ADDR_WIDTH, 8, PADDR / req_addr width
- DATA_WIDTH, 32, PWDATA / PRDATA / req_wdata / rsp_rdata width
- REQ_DEPTH, 4, request FIFO entries (power of two, ≥2)
- TIMEOUT_CYCLES, 16, PREADY wait limit (used only with APB_MASTER_TIMEOUT_EN)

Ports:
- PCLK  in  1  clock; one clock domain, everything on rising edge
- PRESETn  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request FIFO not full
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  PSLVERR (or timeout) of the completed transfer
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY, PSLVERR  in  1  APB completion and error

## Operation
- Request push: `req_valid && req_ready` at a rising edge. `req_ready = !fifo_full`.
- Request FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: if the FIFO is non-empty, pop the head, register it onto PADDR/PWRITE/PWDATA, and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0. Next state is ACCESS unconditionally.
  - ACCESS: PSEL=1, PENABLE=1. Stay while PREADY=0. When PREADY=1:
    - capture PRDATA (reads only; writes load 0) into rsp_rdata;
    - capture PSLVERR into rsp_err;
    - drop PSEL/PENABLE;
    - go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until `rsp_ready`. On `rsp_ready`:
    - FIFO non-empty: pop the next entry and go directly to SETUP;
    - FIFO empty: go to IDLE.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle. They hold their last value outside transfers.
- Simultaneous push and pop in the same cycle is legal. The FIFO count is unchanged. A push when full cannot occur.
- Pointers wrap modulo REQ_DEPTH. An extra wrap bit distinguishes full from empty.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. FIFO empty, FSM in IDLE.
- req_ready is 0 during any cycle with PRESETn=0.
- Reset asserted mid-transfer: PSEL/PENABLE drop at that edge, the in-flight transfer and all queued requests are discarded, and no response is issued.

## Timing
- Request accepted at edge N: IDLE during cycle N+1, SETUP in cycle N+2, ACCESS in cycle N+3.
- With PREADY=1 in the first ACCESS cycle: rsp_valid=1 in cycle N+4. Minimum latency is 4 cycles.
- Each PREADY wait state adds 1 cycle.
- Back-to-back queued requests: next SETUP follows the cycle in which the response handshake completes. APB throughput is one transfer per 3 cycles when rsp_ready is held high.
- All outputs are registered except req_ready, which is combinational from FIFO state and PRESETn.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - a counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0;
  - when it reaches TIMEOUT_CYCLES, drop PSEL/PENABLE and go to RESP with rsp_err=1, rsp_rdata=0;
  - a late PREADY is ignored.
- Not defined: no counter logic; ACCESS waits for PREADY indefinitely.

## Structure
- Package `apb_master_pkg`: FSM state enum (IDLE, SETUP, ACCESS, RESP) and the request entry struct {write, addr, wdata}.
- Sub-module `apb_req_fifo`: synchronous FIFO, parameterised on depth and entry type. Ports: push/pop, full/empty, head entry. Output is combinational from registered storage.

## Test plan
- Single write then read: write 0xDEADBEEF to 0x10; read 0x10 with PREADY tied high.
  - Response 1: rsp_err=0, rsp_rdata=0.
  - Response 2: rsp_rdata=0xDEADBEEF.
  - Check SETUP→ACCESS ordering and latency 4 for each.
- Wait states: slave holds PREADY low for 3 ACCESS cycles on a read of 0x04. Expect:
  - PENABLE high for 4 cycles;
  - PADDR stable at 0x04 throughout;
  - rsp_valid 7 cycles after acceptance.
- FIFO full and backpressure: hold rsp_ready=0 and push 6 requests.
  - req_ready drops after 4 queued plus 1 in flight.
  - Release rsp_ready; all 5 accepted requests complete in order.
- Error: slave returns PSLVERR=1 on address 0xFC. Expect rsp_err=1 on that response only, and rsp_err=0 on the next transfer.
- Reset mid-transfer: assert PRESETn=0 during ACCESS with 2 requests queued. Expect:
  - PSEL=0 at the next edge;
  - no rsp_valid;
  - FIFO empty after reset;
  - a new request completes normally.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16: PREADY held at 0. Expect PSEL to drop after 16 ACCESS cycles, and the response to carry rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/apb_master_pkg.sv
// apb_master shared types: FSM states and the queued request entry.
// Entry widths match the default ADDR_WIDTH/DATA_WIDTH of apb_master.
package apb_master_pkg;

  localparam int REQ_ADDR_W = 8;
  localparam int REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/apb_req_fifo.sv
// Request FIFO for apb_master: wrap-bit pointers, registered storage,
// combinational head. Push when full is never issued by the parent.
module apb_req_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW:0]   wr_q;
  logic [PW:0]   rd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (PW+1)'(1);
      if (pop)  rd_q <= rd_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PW-1:0]] <= push_entry;
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) &&
                 (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head  = mem_q[rd_q[PW-1:0]];

endmodule

// File: rtl/apb_master.sv
// Command-driven APB master: queued requests, one SETUP/ACCESS at a time.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int REQ_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  state_t     state_q, state_d;
  req_entry_t push_entry, head;
  logic       push, pop, full, empty, launch;

  logic                  psel_q, psel_d;
  logic                  pen_q, pen_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rvld_q, rvld_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
`endif

  assign req_ready = PRESETn && !full;
  assign push      = req_valid && req_ready;

  always_comb begin
    push_entry       = '0;
    push_entry.write = req_write;
    push_entry.addr  = REQ_ADDR_W'(req_addr);
    push_entry.wdata = REQ_DATA_W'(req_wdata);
  end

  apb_req_fifo #(
    .DEPTH   (REQ_DEPTH),
    .entry_t (req_entry_t)
  ) u_fifo (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  always_comb begin
    state_d  = state_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rvld_d   = rvld_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    launch   = 1'b0;
    pop      = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    tcnt_d   = tcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty) launch = 1'b1;
      end
      SETUP: begin
        pen_d   = 1'b1;
        state_d = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        tcnt_d  = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rvld_d  = 1'b1;
          rdata_d = pwrite_q ? '0 : PRDATA;
          rerr_d  = PSLVERR;
          state_d = RESP;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rvld_d  = 1'b1;
          rdata_d = '0;
          rerr_d  = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d  = tcnt_q + TW'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rvld_d = 1'b0;
          if (!empty) launch  = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Pop the head straight into the APB address/data registers
    if (launch) begin
      pop      = 1'b1;
      psel_d   = 1'b1;
      pen_d    = 1'b0;
      pwrite_d = head.write;
      paddr_d  = ADDR_WIDTH'(head.addr);
      pwdata_d = DATA_WIDTH'(head.wdata);
      state_d  = SETUP;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rvld_q   <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rvld_q   <= rvld_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK) begin
    if (!PRESETn) tcnt_q <= '0;
    else          tcnt_q <= tcnt_d;
  end
`endif

  assign PSEL      = psel_q;
  assign PENABLE   = pen_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rvld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small APB slave model.
// Unwritten slave words read back as {24'hC0FFEE, addr}; 0xFC errors.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  int n_checks = 0;
  int n_pass   = 0;
  int waits    = 0;
  int acc_cnt  = 0;

  logic [31:0]  mem [256];
  logic [255:0] wr_vld = '0;

  always #5 PCLK = ~PCLK;

  apb_master #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (32),
    .REQ_DEPTH      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  assign PREADY  = PSEL && PENABLE && (acc_cnt >= waits);
  assign PSLVERR = PSEL && PENABLE && (PADDR == 8'hFC);
  assign PRDATA  = wr_vld[PADDR] ? mem[PADDR] : {24'hC0FFEE, PADDR};

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) begin
      mem[PADDR]    <= PWDATA;
      wr_vld[PADDR] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic xfer(input string tag, input logic w,
                      input logic [7:0] a, input logic [31:0] d,
                      input int exp_lat, input int exp_pen,
                      input logic [31:0] exp_rd, input logic exp_err);
    int k, setup_at, access_at, pen, bad;
    bit got;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge PCLK); #1;
      k++;
    end
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    setup_at = -1;
    access_at = -1;
    pen = 0;
    bad = 0;
    got = 1'b0;
    for (k = 1; k <= 60; k++) begin
      @(posedge PCLK); #1;
      if (PSEL && !PENABLE && setup_at < 0) setup_at = k;
      if (PSEL && PENABLE) begin
        pen++;
        if (access_at < 0) access_at = k;
      end
      if (PSEL && (PADDR != a || PWRITE != w)) bad++;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_got"}, 32'(got), 32'd1);
    check({tag, "_lat"}, k + 1, exp_lat);
    check({tag, "_setup"}, setup_at, 1);
    check({tag, "_access"}, access_at, 2);
    check({tag, "_pen"}, pen, exp_pen);
    check({tag, "_addr"}, bad, 0);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    @(posedge PCLK); #1;
    check({tag, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] exp_ord [5] = '{32'hC0FFEE20, 32'hC0FFEE24,
                               32'hC0FFEE28, 32'hC0FFEE2C,
                               32'hC0FFEE30};

  initial begin
    int n_acc, n_rsp, n;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_psel", 32'(PSEL), 0);
    check("rst_pen", 32'(PENABLE), 0);
    check("rst_pwrite", 32'(PWRITE), 0);
    check("rst_paddr", 32'(PADDR), 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rvld", 32'(rsp_valid), 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_rerr", 32'(rsp_err), 0);
    check("rst_ready", 32'(req_ready), 0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("ready_out", 32'(req_ready), 1);

    xfer("wr10", 1'b1, 8'h10, 32'hDEADBEEF, 4, 1, 32'h0, 1'b0);
    xfer("rd10", 1'b0, 8'h10, 32'h0, 4, 1, 32'hDEADBEEF, 1'b0);

    waits = 3;
    xfer("rd04", 1'b0, 8'h04, 32'h0, 7, 4, 32'hC0FFEE04, 1'b0);
    waits = 0;

    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 8'h20 + 8'(4 * i);
      if (req_ready) n_acc++;
      @(posedge PCLK); #1;
    end
    req_valid = 1'b0;
    check("full_acc", n_acc, 5);
    check("full_ready", 32'(req_ready), 0);
    rsp_ready = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid) begin
        if (n_rsp < 5)
          check($sformatf("ord%0d", n_rsp), rsp_rdata, exp_ord[n_rsp]);
        n_rsp++;
      end
      @(posedge PCLK); #1;
    end
    check("full_nrsp", n_rsp, 5);

    xfer("rdFC", 1'b0, 8'hFC, 32'h0, 4, 1, 32'hC0FFEEFC, 1'b1);
    xfer("rd14", 1'b0, 8'h14, 32'h0, 4, 1, 32'hC0FFEE14, 1'b0);

    waits = 20;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 8'h30 + 8'(4 * i);
      @(posedge PCLK); #1;
    end
    req_valid = 1'b0;
    n = 0;
    while (!(PSEL && PENABLE) && n < 10) begin
      @(posedge PCLK); #1;
      n++;
    end
    check("mid_access", 32'(PSEL && PENABLE), 1);
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    check("mid_psel", 32'(PSEL), 0);
    check("mid_pen", 32'(PENABLE), 0);
    check("mid_rvld", 32'(rsp_valid), 0);
    check("mid_ready", 32'(req_ready), 0);
    PRESETn = 1'b1;
    waits = 0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge PCLK); #1;
      if (rsp_valid || PSEL) n++;
    end
    check("mid_quiet", n, 0);
    xfer("post", 1'b0, 8'h38, 32'h0, 4, 1, 32'hC0FFEE38, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
    waits = 1000;
    xfer("tmo", 1'b0, 8'h40, 32'h0, 19, 16, 32'h0, 1'b1);
    waits = 0;
    xfer("tmo_after", 1'b0, 8'h44, 32'h0, 4, 1, 32'hC0FFEE44, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
